riser_mailbox_arb: RTL and testbench
====================================

# riser_mailbox_arb

Arbitrated 16-byte mailbox between the CD32 68020 bus and the ARM-side SPI frame decoder on the USB riser. The block claims 68020 byte cycles that hit its address window: it punts the motherboard, sequences the access and terminates it with DSACK0. It also shares the single mailbox register file with ARM-side requests and raises doorbells in both directions. It sits between the riser's bus pins (A, D[31:24], AS20, DS20, RW, PUNT) and the SPI slave block.

## Interface
Parameters:
- BASE, 24'hB8_0000, window base; match is A[23:4] == BASE[23:4]
- ACK_WAIT, 2, extra CLKCPU_A cycles between data valid and DSACK0 assertion (0..3)

Ports:
- CLKCPU_A  in  1  CPU clock, the only clock; every flop on its rising edge
- RESETn  in  1  synchronous, active-low reset
- AS20, DS20, RW  in  1 each  68020 strobes and direction; synchronous to CLKCPU_A
- A  in  24  CPU address
- D_IN  in  8  CPU data bus D[31:24] read-back
- D_OUT  out  8  read data for D[31:24]
- D_OE  out  1  drive enable for D[31:24]
- PUNT_n  out  1  low = cycle claimed, motherboard suppressed
- DSACK0_n  out  1  8-bit port termination, active low
- ARM_REQ  in  1  ARM access request; held until ARM_ACK
- ARM_WE  in  1  1 = write
- ARM_ADDR  in  4  mailbox index
- ARM_WDATA  in  8  write data
- ARM_RDATA  out  8  read data, valid with ARM_ACK
- ARM_ACK  out  1  one-cycle completion pulse
- ARM_IRQ  out  1  CPU-to-ARM doorbell pending
- CPU_IRQ_n  out  1  ARM-to-CPU doorbell pending, active low

## Operation
- Storage is mailbox regs 0..15, 8 bits each.
- Reg 14 is DOORBELL_TO_ARM. A CPU write stores the data and sets ARM_IRQ. An ARM read of reg 14 clears ARM_IRQ.
- Reg 15 is DOORBELL_TO_CPU. An ARM write stores the data and sets CPU_IRQ_n low. A CPU read of reg 15 clears it.
- A cycle hits when AS20 = 0 and A is in the window. Misses are ignored, with PUNT_n, DSACK0_n and D_OE held at their inactive values.
- FSM states: IDLE, CPU_CLAIM, CPU_DATA, CPU_WAIT, CPU_TERM, ARM_ACC.
- IDLE:
  - If a CPU hit and ARM_REQ are both present, the winner is set by the fairness bit `last_cpu`. When `last_cpu` = 1, ARM wins; otherwise CPU wins.
  - A sole requester always wins.
- CPU_CLAIM: latch A[3:0] and RW; assert PUNT_n = 0. Next state is CPU_DATA.
- CPU_DATA:
  - Writes wait for DS20 = 0, then write D_IN into the register.
  - Reads drive D_OUT = reg and D_OE = 1.
  - Next state is CPU_WAIT, which counts ACK_WAIT cycles; with ACK_WAIT = 0 it passes straight through.
- CPU_TERM: hold DSACK0_n = 0 until AS20 = 1 is sampled, then return to IDLE with `last_cpu` = 1. D_OE, PUNT_n and DSACK0_n deassert in the cycle AS20 = 1 is seen.
- ARM_ACC: one cycle. Perform the read or write, pulse ARM_ACK, set `last_cpu` = 0, return to IDLE.
- Abort: if AS20 rises in any CPU state before CPU_TERM, return to IDLE. No register write takes effect unless the write has already occurred in CPU_DATA.
- Doorbell precedence: if a set and a clear of the same doorbell occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM in IDLE, `last_cpu` = 0, all mailbox regs 0x00.
  - PUNT_n = 1, DSACK0_n = 1, D_OE = 0, D_OUT = 0x00.
  - ARM_ACK = 0, ARM_RDATA = 0x00, ARM_IRQ = 0, CPU_IRQ_n = 1.
- Reset asserted mid-cycle: all outputs return to their reset values on the next edge. The CPU then times out through the motherboard's bus error path.
- CPU read, AS20 sampled low at edge N:
  - PUNT_n low at N+1.
  - D_OE and data valid at N+2.
  - DSACK0_n low at N+3+ACK_WAIT.
- CPU write: the register updates on the edge after DS20 is sampled low.
- ARM access granted at IDLE edge M: ARM_ACK and ARM_RDATA valid at M+1. Worst-case ARM wait is one full CPU cycle.
- ARM_REQ is sampled only in IDLE. ARM_REQ held high after ARM_ACK counts as a new request.

## Structure
- Package `riser_pkg`:
  - FSM state enum.
  - Mailbox index constants `MB_DB_TO_ARM` = 14, `MB_DB_TO_CPU` = 15.
  - Default window base.
- Sub-module `mailbox_regfile`: 16x8 storage, one write port, two combinational read ports. The doorbell flags stay in the top level.
- Pin-level tristate (D inout, PUNT) lives in `main_top`, not here.

## Test plan
- CPU write 0xA5 to BASE+3, then CPU read of BASE+3: D_OUT = 0xA5. DSACK0_n low at N+5 with ACK_WAIT = 2, PUNT_n low for the whole cycle.
- Access to BASE+0x10: PUNT_n, DSACK0_n and D_OE never assert; the mailbox is unchanged.
- CPU hit and ARM_REQ in the same cycle straight after reset: CPU served first, ARM_ACK one cycle after the CPU cycle ends. Repeat back-to-back: the two requesters alternate.
- CPU write 0x01 to reg 14: ARM_IRQ = 1. ARM reads reg 14: ARM_RDATA = 0x01, ARM_IRQ = 0. ARM writes reg 15: CPU_IRQ_n = 0 until the CPU reads reg 15.
- AS20 negated during CPU_WAIT: return to IDLE, DSACK0_n never asserts, a pending ARM_REQ is acked the next cycle.
- RESETn low during CPU_TERM: all outputs return to reset values next edge and all regs read 0x00 afterwards.

Source files
------------

// File: rtl/riser_pkg.sv
// riser_pkg
// Shared types and constants for the riser mailbox arbiter.
//   arb_state_t   - arbiter FSM state encoding
//   MB_ENTRIES    - number of mailbox registers
//   MB_DB_TO_ARM  - mailbox index of the CPU-to-ARM doorbell register
//   MB_DB_TO_CPU  - mailbox index of the ARM-to-CPU doorbell register
//   DEFAULT_BASE  - default 68020 address window base
package riser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_CLAIM,
        ST_CPU_DATA,
        ST_CPU_WAIT,
        ST_CPU_TERM,
        ST_ARM_ACC
    } arb_state_t;

    localparam int unsigned MB_ENTRIES   = 16;
    localparam logic [3:0]  MB_DB_TO_ARM = 4'd14;
    localparam logic [3:0]  MB_DB_TO_CPU = 4'd15;
    localparam logic [23:0] DEFAULT_BASE = 24'hB8_0000;

endpackage

// File: rtl/mailbox_regfile.sv
// mailbox_regfile
// 16 x 8-bit mailbox storage shared by the CPU and ARM sides.
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset (clears all entries)
//   we, waddr, wdata  - single write port
//   raddr_a, rdata_a  - combinational read port (CPU side)
//   raddr_b, rdata_b  - combinational read port (ARM side)
module mailbox_regfile
    import riser_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [3:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem [MB_ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '{default: 8'h00};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/riser_mailbox_arb.sv
// riser_mailbox_arb
// Arbitrates a 16-byte mailbox between 68020 byte cycles hitting the BASE
// window and ARM-side requests from the SPI frame decoder, with doorbells
// in both directions.
// Ports:
//   CLKCPU_A, RESETn           - CPU clock, synchronous active-low reset
//   AS20, DS20, RW, A, D_IN    - 68020 strobes, direction, address, write data
//   D_OUT, D_OE                - read data and drive enable for D[31:24]
//   PUNT_n, DSACK0_n           - motherboard suppress, 8-bit termination
//   ARM_REQ/WE/ADDR/WDATA      - ARM request, held until ARM_ACK
//   ARM_RDATA, ARM_ACK         - ARM read data, one-cycle completion
//   ARM_IRQ, CPU_IRQ_n         - doorbell pending flags
module riser_mailbox_arb
    import riser_pkg::*;
#(
    parameter logic [23:0] BASE     = DEFAULT_BASE,
    parameter int unsigned ACK_WAIT = 2
) (
    input  logic        CLKCPU_A,
    input  logic        RESETn,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW,
    input  logic [23:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        PUNT_n,
    output logic        DSACK0_n,
    input  logic        ARM_REQ,
    input  logic        ARM_WE,
    input  logic [3:0]  ARM_ADDR,
    input  logic [7:0]  ARM_WDATA,
    output logic [7:0]  ARM_RDATA,
    output logic        ARM_ACK,
    output logic        ARM_IRQ,
    output logic        CPU_IRQ_n
);

    localparam logic [1:0] ACK_WAIT_CNT = 2'(ACK_WAIT);

    arb_state_t state_q, state_d;
    logic       punt_n_q, punt_n_d;
    logic       dsack_n_q, dsack_n_d;
    logic       d_oe_q, d_oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic       arm_ack_q, arm_ack_d;
    logic [7:0] arm_rdata_q, arm_rdata_d;
    logic [3:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [1:0] wait_q, wait_d;
    logic       last_cpu_q, last_cpu_d;
    logic       arm_irq_q, cpu_irq_q;
    logic       arm_irq_set, arm_irq_clr, cpu_irq_set, cpu_irq_clr;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata, rf_rdata_cpu, rf_rdata_arm;
    logic       cpu_hit;

    assign cpu_hit = !AS20 && (A[23:4] == BASE[23:4]);

    mailbox_regfile u_regfile (
        .clk     (CLKCPU_A),
        .rst_n   (RESETn),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (addr_q),
        .rdata_a (rf_rdata_cpu),
        .raddr_b (ARM_ADDR),
        .rdata_b (rf_rdata_arm)
    );

    // Next-state and next-output logic. Bus outputs are registered so that
    // PUNT_n, D_OE and DSACK0_n change one edge after the state that decides
    // them; AS20 rising in any CPU state before TERM abandons the cycle.
    always_comb begin
        state_d     = state_q;
        punt_n_d    = punt_n_q;
        dsack_n_d   = dsack_n_q;
        d_oe_d      = d_oe_q;
        d_out_d     = d_out_q;
        arm_ack_d   = 1'b0;
        arm_rdata_d = arm_rdata_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wait_d      = wait_q;
        last_cpu_d  = last_cpu_q;
        rf_we       = 1'b0;
        rf_waddr    = 4'd0;
        rf_wdata    = 8'h00;
        arm_irq_set = 1'b0;
        arm_irq_clr = 1'b0;
        cpu_irq_set = 1'b0;
        cpu_irq_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                punt_n_d  = 1'b1;
                dsack_n_d = 1'b1;
                d_oe_d    = 1'b0;
                // last_cpu = 1 hands a contested slot to the ARM side.
                if (cpu_hit && !(ARM_REQ && last_cpu_q)) begin
                    state_d = ST_CPU_CLAIM;
                end else if (ARM_REQ) begin
                    state_d = ST_ARM_ACC;
                end
            end
            ST_CPU_CLAIM: begin
                if (AS20) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d   = A[3:0];
                    rw_d     = RW;
                    punt_n_d = 1'b0;
                    state_d  = ST_CPU_DATA;
                end
            end
            ST_CPU_DATA: begin
                if (AS20) begin
                    punt_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (rw_q) begin
                    d_out_d = rf_rdata_cpu;
                    d_oe_d  = 1'b1;
                    wait_d  = 2'd0;
                    state_d = ST_CPU_WAIT;
                    if (addr_q == MB_DB_TO_CPU) begin
                        cpu_irq_clr = 1'b1;
                    end
                end else if (!DS20) begin
                    rf_we    = 1'b1;
                    rf_waddr = addr_q;
                    rf_wdata = D_IN;
                    wait_d   = 2'd0;
                    state_d  = ST_CPU_WAIT;
                    if (addr_q == MB_DB_TO_ARM) begin
                        arm_irq_set = 1'b1;
                    end
                end
            end
            ST_CPU_WAIT: begin
                if (AS20) begin
                    punt_n_d = 1'b1;
                    d_oe_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (wait_q == ACK_WAIT_CNT) begin
                    dsack_n_d = 1'b0;
                    state_d   = ST_CPU_TERM;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CPU_TERM: begin
                if (AS20) begin
                    punt_n_d   = 1'b1;
                    dsack_n_d  = 1'b1;
                    d_oe_d     = 1'b0;
                    last_cpu_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_ARM_ACC: begin
                arm_ack_d  = 1'b1;
                last_cpu_d = 1'b0;
                state_d    = ST_IDLE;
                if (ARM_WE) begin
                    rf_we    = 1'b1;
                    rf_waddr = ARM_ADDR;
                    rf_wdata = ARM_WDATA;
                    if (ARM_ADDR == MB_DB_TO_CPU) begin
                        cpu_irq_set = 1'b1;
                    end
                end else begin
                    arm_rdata_d = rf_rdata_arm;
                    if (ARM_ADDR == MB_DB_TO_ARM) begin
                        arm_irq_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered bus outputs and doorbell flags. A set of a doorbell
    // overrides a clear of the same doorbell in the same cycle.
    always_ff @(posedge CLKCPU_A) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            punt_n_q    <= 1'b1;
            dsack_n_q   <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= 8'h00;
            arm_ack_q   <= 1'b0;
            arm_rdata_q <= 8'h00;
            addr_q      <= 4'd0;
            rw_q        <= 1'b1;
            wait_q      <= 2'd0;
            last_cpu_q  <= 1'b0;
            arm_irq_q   <= 1'b0;
            cpu_irq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            punt_n_q    <= punt_n_d;
            dsack_n_q   <= dsack_n_d;
            d_oe_q      <= d_oe_d;
            d_out_q     <= d_out_d;
            arm_ack_q   <= arm_ack_d;
            arm_rdata_q <= arm_rdata_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wait_q      <= wait_d;
            last_cpu_q  <= last_cpu_d;
            arm_irq_q   <= arm_irq_set | (arm_irq_q & ~arm_irq_clr);
            cpu_irq_q   <= cpu_irq_set | (cpu_irq_q & ~cpu_irq_clr);
        end
    end

    assign PUNT_n    = punt_n_q;
    assign DSACK0_n  = dsack_n_q;
    assign D_OE      = d_oe_q;
    assign D_OUT     = d_out_q;
    assign ARM_ACK   = arm_ack_q;
    assign ARM_RDATA = arm_rdata_q;
    assign ARM_IRQ   = arm_irq_q;
    assign CPU_IRQ_n = ~cpu_irq_q;

endmodule

// File: tb/tb_riser_mailbox_arb.sv
// tb_riser_mailbox_arb
// Self-checking bench for riser_mailbox_arb: directed scenarios plus a
// randomized transaction stream checked against a transaction-level mailbox
// and doorbell model.
module tb_riser_mailbox_arb;

    localparam logic [23:0] BASE     = 24'hB8_0000;
    localparam int          ACK_WAIT = 2;

    logic        CLKCPU_A;
    logic        RESETn;
    logic        AS20, DS20, RW;
    logic [23:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE, PUNT_n, DSACK0_n;
    logic        ARM_REQ, ARM_WE;
    logic [3:0]  ARM_ADDR;
    logic [7:0]  ARM_WDATA, ARM_RDATA;
    logic        ARM_ACK, ARM_IRQ, CPU_IRQ_n;

    riser_mailbox_arb #(.BASE(BASE), .ACK_WAIT(ACK_WAIT)) dut (
        .CLKCPU_A (CLKCPU_A),
        .RESETn   (RESETn),
        .AS20     (AS20),
        .DS20     (DS20),
        .RW       (RW),
        .A        (A),
        .D_IN     (D_IN),
        .D_OUT    (D_OUT),
        .D_OE     (D_OE),
        .PUNT_n   (PUNT_n),
        .DSACK0_n (DSACK0_n),
        .ARM_REQ  (ARM_REQ),
        .ARM_WE   (ARM_WE),
        .ARM_ADDR (ARM_ADDR),
        .ARM_WDATA(ARM_WDATA),
        .ARM_RDATA(ARM_RDATA),
        .ARM_ACK  (ARM_ACK),
        .ARM_IRQ  (ARM_IRQ),
        .CPU_IRQ_n(CPU_IRQ_n)
    );

    initial begin
        CLKCPU_A = 1'b0;
        forever #5 CLKCPU_A = ~CLKCPU_A;
    end

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    int         ack_cyc = 0;
    logic [7:0] ack_rdata = 8'h00;
    bit         arm_pending = 1'b0;

    // Transaction-level reference model of the mailbox and doorbells.
    logic [7:0] exp_mb [16];
    bit         exp_arm_irq;
    bit         exp_cpu_irq;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) exp_mb[i] = 8'h00;
        exp_arm_irq = 1'b0;
        exp_cpu_irq = 1'b0;
    endfunction

    function automatic void model_cpu_write(input logic [3:0] a, input logic [7:0] d);
        exp_mb[a] = d;
        if (a == 4'd14) exp_arm_irq = 1'b1;
    endfunction

    function automatic logic [7:0] model_cpu_read(input logic [3:0] a);
        if (a == 4'd15) exp_cpu_irq = 1'b0;
        return exp_mb[a];
    endfunction

    function automatic void model_arm_write(input logic [3:0] a, input logic [7:0] d);
        exp_mb[a] = d;
        if (a == 4'd15) exp_cpu_irq = 1'b1;
    endfunction

    function automatic logic [7:0] model_arm_read(input logic [3:0] a);
        if (a == 4'd14) exp_arm_irq = 1'b0;
        return exp_mb[a];
    endfunction

    // One clock: step past the edge, record any ARM completion and drop the
    // request the bench was holding for it.
    task automatic tick();
        @(posedge CLKCPU_A);
        #1;
        cyc++;
        if (ARM_ACK === 1'b1) begin
            ack_cnt++;
            ack_cyc   = cyc;
            ack_rdata = ARM_RDATA;
            if (arm_pending) begin
                ARM_REQ     = 1'b0;
                arm_pending = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        RESETn = 1'b0; AS20 = 1'b1; DS20 = 1'b1; RW = 1'b1;
        A = 24'h00_0000; D_IN = 8'h00;
        ARM_REQ = 1'b0; ARM_WE = 1'b0; ARM_ADDR = 4'd0; ARM_WDATA = 8'h00;
        arm_pending = 1'b0;
        tick(); tick();
        RESETn = 1'b1;
        model_reset();
    endtask

    task automatic arm_start(input bit we, input logic [3:0] addr, input logic [7:0] wdata);
        ARM_WE = we; ARM_ADDR = addr; ARM_WDATA = wdata;
        ARM_REQ = 1'b1; arm_pending = 1'b1;
    endtask

    task automatic arm_wait(input int prev, output bit ok);
        ok = (ack_cnt != prev);
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = (ack_cnt != prev);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL arm_ack_timeout: got no ARM_ACK, required one within 20 cycles");
        end
    endtask

    task automatic arm_access(input bit we, input logic [3:0] addr, input logic [7:0] wdata,
                              output logic [7:0] rdata);
        int prev;
        bit ok;
        prev = ack_cnt;
        arm_start(we, addr, wdata);
        arm_wait(prev, ok);
        rdata = ack_rdata;
    endtask

    // Runs one claimed 68020 byte cycle; edge indices are relative to the
    // first edge that samples AS20 low (index 0).
    task automatic cpu_cycle(input logic [23:0] addr, input bit is_read, input logic [7:0] wdata,
                             input int ds_delay, output logic [7:0] rdata,
                             output int punt_e, output int doe_e, output int dsack_e,
                             output bit punt_held, output bit end_clean);
        punt_e = -1; doe_e = -1; dsack_e = -1; punt_held = 1'b1; end_clean = 1'b0; rdata = 8'h00;
        A = addr; RW = is_read; D_IN = wdata; AS20 = 1'b0;
        DS20 = (is_read || ds_delay == 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < 40 && dsack_e < 0; i++) begin
            tick();
            if (!is_read && i + 1 >= ds_delay) DS20 = 1'b0;
            if (PUNT_n === 1'b0 && punt_e < 0) punt_e = i;
            if (punt_e >= 0 && PUNT_n !== 1'b0) punt_held = 1'b0;
            if (D_OE === 1'b1 && doe_e < 0) begin
                doe_e = i;
                rdata = D_OUT;
            end
            if (DSACK0_n === 1'b0) dsack_e = i;
        end
        tests_run++;
        if (dsack_e < 0) begin
            tests_failed++;
            $display("[TB] FAIL cpu_dsack_timeout: addr %h got no DSACK0_n, required within 40 cycles", addr);
        end
        AS20 = 1'b1; DS20 = 1'b1;
        tick();
        end_clean = (PUNT_n === 1'b1 && DSACK0_n === 1'b1 && D_OE === 1'b0);
        A = 24'h00_0000; RW = 1'b1;
    endtask

    // Holds an out-of-window strobe for several cycles, reporting whether any
    // bus output was driven active.
    task automatic miss_cycle(input logic [23:0] addr, input bit is_read, input logic [7:0] wdata,
                              output bit asserted);
        asserted = 1'b0;
        A = addr; RW = is_read; D_IN = wdata; AS20 = 1'b0; DS20 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (PUNT_n !== 1'b1 || DSACK0_n !== 1'b1 || D_OE !== 1'b0) asserted = 1'b1;
        end
        AS20 = 1'b1; DS20 = 1'b1; A = 24'h00_0000; RW = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (PUNT_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_punt: got %b want 1", PUNT_n); end
        tests_run++; if (DSACK0_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_dsack: got %b want 1", DSACK0_n); end
        tests_run++; if (D_OE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_doe: got %b want 0", D_OE); end
        tests_run++; if (D_OUT !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h want 00", D_OUT); end
        tests_run++; if (ARM_ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b want 0", ARM_ACK); end
        tests_run++; if (ARM_RDATA !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h want 00", ARM_RDATA); end
        tests_run++; if (ARM_IRQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_arm_irq: got %b want 0", ARM_IRQ); end
        tests_run++; if (CPU_IRQ_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cpu_irq: got %b want 1", CPU_IRQ_n); end
    endtask

    task automatic test_cpu_write_read();
        logic [7:0] rd;
        int pe, de, se;
        bit ph, ec;
        cpu_cycle(BASE + 24'h3, 1'b0, 8'hA5, 0, rd, pe, de, se, ph, ec);
        model_cpu_write(4'd3, 8'hA5);
        tests_run++; if (pe !== 1) begin tests_failed++; $display("[TB] FAIL wr_punt_edge: got %0d want 1", pe); end
        tests_run++; if (!ec) begin tests_failed++; $display("[TB] FAIL wr_end_clean: got 0 want 1"); end
        cpu_cycle(BASE + 24'h3, 1'b1, 8'h00, 0, rd, pe, de, se, ph, ec);
        tests_run++; if (rd !== model_cpu_read(4'd3)) begin tests_failed++; $display("[TB] FAIL rd_data: got %h want %h", rd, exp_mb[3]); end
        tests_run++; if (pe !== 1) begin tests_failed++; $display("[TB] FAIL rd_punt_edge: got %0d want 1", pe); end
        tests_run++; if (de !== 2) begin tests_failed++; $display("[TB] FAIL rd_doe_edge: got %0d want 2", de); end
        tests_run++; if (se !== 3 + ACK_WAIT) begin tests_failed++; $display("[TB] FAIL rd_dsack_edge: got %0d want %0d", se, 3 + ACK_WAIT); end
        tests_run++; if (!ph) begin tests_failed++; $display("[TB] FAIL rd_punt_held: got 0 want 1"); end
        tests_run++; if (!ec) begin tests_failed++; $display("[TB] FAIL rd_end_clean: got 0 want 1"); end
    endtask

    task automatic test_miss();
        bit asserted;
        logic [7:0] rd;
        miss_cycle(BASE + 24'h13, 1'b0, 8'h5A, asserted);
        tests_run++; if (asserted) begin tests_failed++; $display("[TB] FAIL miss_write_outputs: got active want inactive"); end
        miss_cycle(BASE + 24'h13, 1'b1, 8'h00, asserted);
        tests_run++; if (asserted) begin tests_failed++; $display("[TB] FAIL miss_read_outputs: got active want inactive"); end
        arm_access(1'b0, 4'd3, 8'h00, rd);
        tests_run++; if (rd !== model_arm_read(4'd3)) begin tests_failed++; $display("[TB] FAIL miss_mailbox: got %h want %h", rd, exp_mb[3]); end
    endtask

    task automatic test_arbitration();
        logic [7:0] rd, wd;
        int pe, de, se, prev, end_cyc, start;
        bit ph, ec, ok;
        do_reset();
        // Round A: both at once with last_cpu = 0, the CPU goes first.
        wd = 8'($urandom);
        prev = ack_cnt;
        arm_start(1'b1, 4'd7, wd);
        cpu_cycle(BASE + 24'h2, 1'b0, 8'h3C, 0, rd, pe, de, se, ph, ec);
        end_cyc = cyc;
        model_cpu_write(4'd2, 8'h3C);
        tests_run++; if (pe !== 1) begin tests_failed++; $display("[TB] FAIL arb_cpu_first: punt edge got %0d want 1", pe); end
        arm_wait(prev, ok);
        model_arm_write(4'd7, wd);
        tests_run++;
        if (ok && (ack_cyc <= end_cyc || ack_cyc > end_cyc + 2)) begin
            tests_failed++;
            $display("[TB] FAIL arb_arm_after_cpu: ack at cycle %0d, cpu ended %0d, want %0d..%0d", ack_cyc, end_cyc, end_cyc + 1, end_cyc + 2);
        end
        // Round B: CPU alone, leaving last_cpu = 1.
        cpu_cycle(BASE + 24'h7, 1'b1, 8'h00, 0, rd, pe, de, se, ph, ec);
        tests_run++; if (rd !== model_cpu_read(4'd7)) begin tests_failed++; $display("[TB] FAIL arb_arm_wrote: got %h want %h", rd, exp_mb[7]); end
        // Round C: both at once with last_cpu = 1, the ARM goes first.
        prev = ack_cnt;
        start = cyc;
        arm_start(1'b0, 4'd2, 8'h00);
        cpu_cycle(BASE + 24'h2, 1'b1, 8'h00, 0, rd, pe, de, se, ph, ec);
        tests_run++;
        if (ack_cnt == prev || ack_cyc - start - 1 != 1) begin
            tests_failed++;
            $display("[TB] FAIL arb_arm_first: ack edge got %0d want 1", ack_cyc - start - 1);
        end
        tests_run++; if (ack_rdata !== model_arm_read(4'd2)) begin tests_failed++; $display("[TB] FAIL arb_arm_rdata: got %h want %h", ack_rdata, exp_mb[2]); end
        tests_run++; if (pe !== 3) begin tests_failed++; $display("[TB] FAIL arb_cpu_second: punt edge got %0d want 3", pe); end
        tests_run++; if (rd !== model_cpu_read(4'd2)) begin tests_failed++; $display("[TB] FAIL arb_cpu_rdata: got %h want %h", rd, exp_mb[2]); end
    endtask

    task automatic test_doorbells();
        logic [7:0] rd, wd;
        int pe, de, se;
        bit ph, ec;
        cpu_cycle(BASE + 24'hE, 1'b0, 8'h01, 1, rd, pe, de, se, ph, ec);
        model_cpu_write(4'd14, 8'h01);
        tests_run++; if (ARM_IRQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL db_arm_irq_set: got %b want 1", ARM_IRQ); end
        arm_access(1'b0, 4'd14, 8'h00, rd);
        tests_run++; if (rd !== model_arm_read(4'd14)) begin tests_failed++; $display("[TB] FAIL db_arm_rdata: got %h want 01", rd); end
        tests_run++; if (ARM_IRQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL db_arm_irq_clr: got %b want 0", ARM_IRQ); end
        wd = 8'($urandom);
        arm_access(1'b1, 4'd15, wd, rd);
        model_arm_write(4'd15, wd);
        tick(); tick();
        tests_run++; if (CPU_IRQ_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL db_cpu_irq_set: got %b want 0", CPU_IRQ_n); end
        cpu_cycle(BASE + 24'hF, 1'b1, 8'h00, 0, rd, pe, de, se, ph, ec);
        tests_run++; if (rd !== model_cpu_read(4'd15)) begin tests_failed++; $display("[TB] FAIL db_cpu_rdata: got %h want %h", rd, exp_mb[15]); end
        tests_run++; if (CPU_IRQ_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL db_cpu_irq_clr: got %b want 1", CPU_IRQ_n); end
    endtask

    task automatic test_abort();
        int prev, abort_cyc;
        bit dsack_seen, ok;
        logic [7:0] rd, junk;
        // Read abandoned while waiting to terminate, ARM request pending.
        A = BASE + 24'h4; RW = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
        tick(); tick(); tick();
        prev = ack_cnt;
        AS20 = 1'b1; DS20 = 1'b1;
        arm_start(1'b0, 4'd3, 8'h00);
        dsack_seen = 1'b0;
        tick();
        abort_cyc = cyc;
        tests_run++; if (PUNT_n !== 1'b1 || D_OE !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_release: punt %b oe %b want 1 0", PUNT_n, D_OE); end
        for (int i = 0; i < 6; i++) begin
            if (DSACK0_n !== 1'b1) dsack_seen = 1'b1;
            tick();
        end
        tests_run++; if (dsack_seen) begin tests_failed++; $display("[TB] FAIL abort_no_dsack: got DSACK0_n low want high"); end
        ok = (ack_cnt != prev);
        tests_run++;
        if (!ok || ack_cyc - abort_cyc > 2) begin
            tests_failed++;
            $display("[TB] FAIL abort_arm_ack: ack seen %b, %0d cycles after abort, want within 2", ok, ack_cyc - abort_cyc);
        end
        if (!ok) begin ARM_REQ = 1'b0; arm_pending = 1'b0; end
        tests_run++; if (ack_rdata !== model_arm_read(4'd3)) begin tests_failed++; $display("[TB] FAIL abort_arm_rdata: got %h want %h", ack_rdata, exp_mb[3]); end
        // Write abandoned before DS20 ever asserts: no register change.
        junk = ~exp_mb[6];
        A = BASE + 24'h6; RW = 1'b0; D_IN = junk; AS20 = 1'b0; DS20 = 1'b1;
        tick(); tick(); tick();
        AS20 = 1'b1;
        dsack_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (DSACK0_n !== 1'b1) dsack_seen = 1'b1;
        end
        A = 24'h00_0000; RW = 1'b1;
        tests_run++; if (dsack_seen) begin tests_failed++; $display("[TB] FAIL abort_wr_no_dsack: got DSACK0_n low want high"); end
        arm_access(1'b0, 4'd6, 8'h00, rd);
        tests_run++; if (rd !== model_arm_read(4'd6)) begin tests_failed++; $display("[TB] FAIL abort_wr_unchanged: got %h want %h", rd, exp_mb[6]); end
    endtask

    task automatic test_reset_in_term();
        logic [7:0] rd;
        int pe, de, se;
        bit ph, ec, in_term;
        cpu_cycle(BASE + 24'hE, 1'b0, 8'h77, 0, rd, pe, de, se, ph, ec);
        model_cpu_write(4'd14, 8'h77);
        arm_access(1'b1, 4'd15, 8'h99, rd);
        model_arm_write(4'd15, 8'h99);
        cpu_cycle(BASE + 24'h9, 1'b0, 8'h42, 0, rd, pe, de, se, ph, ec);
        model_cpu_write(4'd9, 8'h42);
        A = BASE + 24'h9; RW = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
        in_term = 1'b0;
        for (int i = 0; i < 20 && !in_term; i++) begin
            tick();
            in_term = (DSACK0_n === 1'b0);
        end
        tests_run++; if (!in_term) begin tests_failed++; $display("[TB] FAIL rst_term_reach: got no DSACK0_n want low within 20"); end
        RESETn = 1'b0; AS20 = 1'b1; DS20 = 1'b1;
        tick();
        tests_run++; if (PUNT_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_term_punt: got %b want 1", PUNT_n); end
        tests_run++; if (DSACK0_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_term_dsack: got %b want 1", DSACK0_n); end
        tests_run++; if (D_OE !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_term_doe: got %b want 0", D_OE); end
        tests_run++; if (D_OUT !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_term_dout: got %h want 00", D_OUT); end
        tests_run++; if (ARM_RDATA !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_term_rdata: got %h want 00", ARM_RDATA); end
        tests_run++; if (ARM_IRQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_term_arm_irq: got %b want 0", ARM_IRQ); end
        tests_run++; if (CPU_IRQ_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_term_cpu_irq: got %b want 1", CPU_IRQ_n); end
        RESETn = 1'b1; A = 24'h00_0000; RW = 1'b1;
        model_reset();
        tick();
        for (int r = 0; r < 16; r++) begin
            arm_access(1'b0, 4'(r), 8'h00, rd);
            tests_run++; if (rd !== model_arm_read(4'(r))) begin tests_failed++; $display("[TB] FAIL rst_term_reg%0d: got %h want 00", r, rd); end
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d, expd;
        logic [3:0] a;
        logic [19:0] xr;
        int op, pe, de, se;
        bit ph, ec, asserted;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            case (op)
                0: begin
                    cpu_cycle(BASE + 24'(a), 1'b0, d, $urandom_range(0, 3), rd, pe, de, se, ph, ec);
                    model_cpu_write(a, d);
                    tests_run++; if (pe !== 1 || !ph || !ec) begin tests_failed++; $display("[TB] FAIL rnd_cpu_wr_bus: punt edge %0d held %b clean %b want 1 1 1", pe, ph, ec); end
                end
                1: begin
                    cpu_cycle(BASE + 24'(a), 1'b1, 8'h00, 0, rd, pe, de, se, ph, ec);
                    expd = model_cpu_read(a);
                    tests_run++; if (rd !== expd) begin tests_failed++; $display("[TB] FAIL rnd_cpu_rd reg%0d: got %h want %h", a, rd, expd); end
                    tests_run++; if (se !== 3 + ACK_WAIT) begin tests_failed++; $display("[TB] FAIL rnd_cpu_rd_dsack: got %0d want %0d", se, 3 + ACK_WAIT); end
                end
                2: begin
                    arm_access(1'b1, a, d, rd);
                    model_arm_write(a, d);
                end
                3: begin
                    arm_access(1'b0, a, 8'h00, rd);
                    expd = model_arm_read(a);
                    tests_run++; if (rd !== expd) begin tests_failed++; $display("[TB] FAIL rnd_arm_rd reg%0d: got %h want %h", a, rd, expd); end
                end
                default: begin
                    xr = 20'($urandom_range(1, 20'hF_FFFF));
                    miss_cycle({BASE[23:4] ^ xr, a}, op[0], d, asserted);
                    tests_run++; if (asserted) begin tests_failed++; $display("[TB] FAIL rnd_miss: got active outputs want inactive"); end
                end
            endcase
            tests_run++; if (ARM_IRQ !== exp_arm_irq) begin tests_failed++; $display("[TB] FAIL rnd_arm_irq: got %b want %b", ARM_IRQ, exp_arm_irq); end
            tests_run++; if (CPU_IRQ_n !== !exp_cpu_irq) begin tests_failed++; $display("[TB] FAIL rnd_cpu_irq_n: got %b want %b", CPU_IRQ_n, !exp_cpu_irq); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_miss();
        test_arbitration();
        test_doorbells();
        test_abort();
        test_reset_in_term();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
